// File: rtl/wb_write_monitor.sv
// rtl/wb_write_monitor.sv - snoops register-file writes into a circular FIFO and steps through them for the seven-segment display
module wb_write_monitor #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter bit FILTER_ZERO = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     WrValid,
    input  logic [4:0]               WrAddr,
    input  logic [31:0]              WrData,
    input  logic [31:0]              WrPC,
    input  logic                     Freeze,
    output logic [12:0]              DispData,
    output logic [12:0]              DispPC,
    output logic [4:0]               DispAddr,
    output logic                     DispValid,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ovf_q, ovf_d;

    logic          push, pop, drop, full, terminal;

    // Only the low 13 bits are ever displayed, so only those are stored.
    logic [4:0]    addr_mem [DEPTH];
    logic [12:0]   data_mem [DEPTH];
    logic [12:0]   pc_mem   [DEPTH];

    logic          unused_upper_bits;
    assign unused_upper_bits = ^{WrData[31:13], WrPC[31:13]};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[tail_q] <= WrAddr;
            data_mem[tail_q] <= WrData[12:0];
            pc_mem[tail_q]   <= WrPC[12:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q;

        push     = WrValid && !(FILTER_ZERO && (WrAddr == 5'd0));
        full     = (count_q == FULL_COUNT);
        terminal = (state_q == SHOW) && !Freeze && (hold_q == HOLD_LAST);
        // The last remaining entry is never popped; it stays on display.
        pop      = terminal && (count_q >= CW'(2));
        // A push into a full FIFO with no pop this cycle evicts the oldest entry.
        drop     = push && full && !pop;

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop || drop) begin
            head_d = head_q + PW'(1);
        end

        if (push && !pop && !full) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (push) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // Freeze takes priority: the counter holds even if an eviction moves the head.
                if (Freeze) begin
                    hold_d = hold_q;
                end else if (drop || terminal) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign DispValid = (state_q == SHOW);
    assign DispData  = DispValid ? data_mem[head_q] : 13'd0;
    assign DispPC    = DispValid ? pc_mem[head_q]   : 13'd0;
    assign DispAddr  = DispValid ? addr_mem[head_q] : 5'd0;
    assign Count     = count_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_wb_write_monitor.sv
// tb/tb_wb_write_monitor.sv - randomized and directed checks of wb_write_monitor against a queue-based reference model
module tb_wb_write_monitor;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        WrValid = 1'b0;
    logic [4:0]  WrAddr = '0;
    logic [31:0] WrData = '0;
    logic [31:0] WrPC = '0;
    logic        Freeze = 1'b0;

    logic [12:0]   a_data, a_pc, b_data, b_pc;
    logic [4:0]    a_addr, b_addr;
    logic          a_valid, b_valid, a_ovf, b_ovf;
    logic [CW-1:0] a_count, b_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    wb_write_monitor #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .FILTER_ZERO(1'b1)) dut_a (
        .Clk(Clk), .Rst(Rst), .WrValid(WrValid), .WrAddr(WrAddr), .WrData(WrData), .WrPC(WrPC),
        .Freeze(Freeze), .DispData(a_data), .DispPC(a_pc), .DispAddr(a_addr), .DispValid(a_valid),
        .Count(a_count), .Overflow(a_ovf));

    wb_write_monitor #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .FILTER_ZERO(1'b0)) dut_b (
        .Clk(Clk), .Rst(Rst), .WrValid(WrValid), .WrAddr(WrAddr), .WrData(WrData), .WrPC(WrPC),
        .Freeze(Freeze), .DispData(b_data), .DispPC(b_pc), .DispAddr(b_addr), .DispValid(b_valid),
        .Count(b_count), .Overflow(b_ovf));

    // Reference model: index 0 mirrors dut_a (zero filtered), index 1 mirrors dut_b.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t mq [2][$];
    int   mhold  [2];
    bit   mshown [2];
    bit   movf   [2];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mhold[k]  = 0;
            mshown[k] = 1'b0;
            movf[k]   = 1'b0;
        end
    endfunction

    function automatic void model_step(int k);
        bit   fz;
        bit   push, term, pop, drop;
        int   n;
        ent_t e;
        fz   = (k == 0);
        push = WrValid && !(fz && WrAddr == 5'd0);
        n    = mq[k].size();
        term = mshown[k] && !Freeze && (mhold[k] == HOLD - 1);
        pop  = term && (n >= 2);
        drop = push && (n == DEPTH) && !pop;
        if (pop || drop) void'(mq[k].pop_front());
        if (drop) movf[k] = 1'b1;
        if (push) begin
            e.a = WrAddr; e.d = WrData; e.pc = WrPC;
            mq[k].push_back(e);
        end
        if (!mshown[k]) mhold[k] = 0;
        else if (Freeze) mhold[k] = mhold[k];
        else if (drop || term) mhold[k] = 0;
        else mhold[k] = mhold[k] + 1;
        if (push) mshown[k] = 1'b1;
    endfunction

    function automatic logic [35:0] model_view(int k);
        logic [12:0] d, pc;
        logic [4:0]  a;
        d = '0; pc = '0; a = '0;
        if (mshown[k]) begin
            d  = mq[k][0].d[12:0];
            pc = mq[k][0].pc[12:0];
            a  = mq[k][0].a;
        end
        return {mshown[k], d, pc, a, CW'(mq[k].size()), movf[k]};
    endfunction

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic f);
        WrValid = v; WrAddr = a; WrData = d; WrPC = pc; Freeze = f;
        @(posedge Clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        WrValid = 1'b0; WrAddr = '0; WrData = '0; WrPC = '0; Freeze = 1'b0;
        Rst = 1'b1;
        model_clear();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
            n_checks++;
            if ({a_valid, a_data, a_pc, a_addr, a_count, a_ovf} !== 36'd0) begin
                $display("FAIL reset_idle_a cycle %0d: got %h want 0", i, {a_valid, a_data, a_pc, a_addr, a_count, a_ovf});
            end else n_pass++;
            n_checks++;
            if ({b_valid, b_data, b_count} !== 17'd0) begin
                $display("FAIL reset_idle_b cycle %0d: got %h want 0", i, {b_valid, b_data, b_count});
            end else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 5'd5, 32'h1234, 32'h40, 1'b0);
        n_checks++;
        if ({a_valid, a_data, a_pc, a_addr} !== {1'b1, 13'h1234, 13'h040, 5'd5}) begin
            $display("FAIL single_show: got v=%0d d=%h pc=%h a=%0d want v=1 d=1234 pc=040 a=5", a_valid, a_data, a_pc, a_addr);
        end else n_pass++;
        for (int i = 0; i < 10; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (a_count !== 3'd1 || a_data !== 13'h1234 || a_valid !== 1'b1) begin
            $display("FAIL single_hold: got count=%0d d=%h v=%0d want count=1 d=1234 v=1", a_count, a_data, a_valid);
        end else n_pass++;
    endtask

    task automatic test_three();
        logic [12:0] exp_d;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(i < 3, 5'd7, 32'(i + 1), 32'(16 * i), 1'b0);
            exp_d = (i < 4) ? 13'd1 : (i < 8) ? 13'd2 : 13'd3;
            n_checks++;
            if (a_data !== exp_d) begin
                $display("FAIL three_data sample %0d: got %0d want %0d", i, a_data, exp_d);
            end else n_pass++;
            n_checks++;
            if (a_count !== CW'(mq[0].size())) begin
                $display("FAIL three_count sample %0d: got %0d want %0d", i, a_count, mq[0].size());
            end else n_pass++;
        end
    endtask

    task automatic test_filter();
        do_reset();
        drive(1'b1, 5'd0, 32'h55, 32'h80, 1'b0);
        n_checks++;
        if (a_count !== 3'd0 || a_valid !== 1'b0 || a_data !== 13'd0) begin
            $display("FAIL filter_zero_on: got count=%0d v=%0d d=%h want 0 0 0", a_count, a_valid, a_data);
        end else n_pass++;
        n_checks++;
        if (b_count !== 3'd1 || b_valid !== 1'b1 || b_data !== 13'h55 || b_addr !== 5'd0) begin
            $display("FAIL filter_zero_off: got count=%0d v=%0d d=%h want 1 1 55", b_count, b_valid, b_data);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, 5'd9, 32'(i), 32'(i), 1'b1);
        n_checks++;
        if (a_ovf !== 1'b1 || a_count !== 3'd4 || a_data !== 13'd2) begin
            $display("FAIL overflow_set: got ovf=%0d count=%0d d=%0d want 1 4 2", a_ovf, a_count, a_data);
        end else n_pass++;
        for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (a_ovf !== 1'b1 || a_count !== 3'd1 || a_data !== 13'd5) begin
            $display("FAIL overflow_sticky: got ovf=%0d count=%0d d=%0d want 1 1 5", a_ovf, a_count, a_data);
        end else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        drive(1'b1, 5'd3, 32'd10, 32'h100, 1'b0);
        drive(1'b1, 5'd3, 32'd20, 32'h104, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
            n_checks++;
            if (a_data !== 13'd10 || a_count !== 3'd2) begin
                $display("FAIL freeze_hold cycle %0d: got d=%0d count=%0d want 10 2", i, a_data, a_count);
            end else n_pass++;
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (a_data !== 13'd10) begin
            $display("FAIL freeze_remaining: got d=%0d want 10", a_data);
        end else n_pass++;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (a_data !== 13'd20 || a_count !== 3'd1) begin
            $display("FAIL freeze_advance: got d=%0d count=%0d want 20 1", a_data, a_count);
        end else n_pass++;
        drive(1'b1, 5'd4, 32'd30, 32'h108, 1'b0);
        Rst = 1'b1;
        #1;
        n_checks++;
        if ({a_valid, a_data, a_pc, a_addr, a_count, a_ovf} !== 36'd0) begin
            $display("FAIL async_reset: got %h want 0", {a_valid, a_data, a_pc, a_addr, a_count, a_ovf});
        end else n_pass++;
        model_clear();
        WrValid = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_random();
        logic [35:0] got, want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 7) == 0);
            for (int k = 0; k < 2; k++) begin
                got  = (k == 0) ? {a_valid, a_data, a_pc, a_addr, a_count, a_ovf}
                                : {b_valid, b_data, b_pc, b_addr, b_count, b_ovf};
                want = model_view(k);
                n_checks++;
                if (got !== want) begin
                    $display("FAIL random inst %0d cycle %0d: got %h want %h", k, i, got, want);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_filter();
        test_overflow();
        test_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_write_monitor.md
# wb_write_monitor

Debug capture block that sits directly downstream of the write-back stage. It snoops every register-file write (RegWrite, destination, data, PC) leaving MEM/WB and buffers it in a small circular FIFO. A hold/advance sequencer steps through the buffered writes at a human-visible rate. It drives the 13-bit NumberA/NumberB inputs of the 8-digit seven-segment display, replacing the unconnected WriteOutput/PCOutput registers.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- HOLD_CYCLES, 50_000_000: Clk cycles each entry is displayed; at least 1.
- FILTER_ZERO, 1: when 1, writes with WrAddr==0 are ignored.

Ports:
- Clk  in  1  single clock for all state (the CPU clock, ClkOut, at top level).
- Rst  in  1  asynchronous, active-high reset.
- WrValid  in  1  MEMWB RegWrite qualifier.
- WrAddr  in  5  MEMWB destination register.
- WrData  in  32  write-back data (WB MemToReg output).
- WrPC  in  32  MEMWB PC.
- Freeze  in  1  holds the current display; captures continue.
- DispData  out  13  WrData[12:0] of the head entry.
- DispPC  out  13  WrPC[12:0] of the head entry.
- DispAddr  out  5  WrAddr of the head entry.
- DispValid  out  1  head entry valid (state SHOW).
- Count  out  log2(DEPTH)+1  current occupancy.
- Overflow  out  1  sticky; set when an entry was overwritten.

## Operation
- Push condition: WrValid & ~(FILTER_ZERO & WrAddr==0). The block stores {WrAddr, WrData, WrPC} at the tail and increments the tail pointer modulo DEPTH.
- Push when full with no pop:
  - The oldest entry is discarded: head advances, tail writes.
  - Count stays at DEPTH.
  - Overflow sets and remains set until Rst.
- Push and pop in the same cycle: Count is unchanged. When full, the pop frees the slot, so no overflow is raised.
- State machine:
  - IDLE, when Count==0: DispValid=0, all Disp* outputs = 0, and the hold counter is held at 0.
  - A push in IDLE moves the block to SHOW on the next edge with the hold counter at 0.
  - In SHOW, the hold counter increments each cycle while Freeze==0.
  - At terminal count (HOLD_CYCLES-1):
    - If Count>=2, pop the head and restart the counter at 0.
    - If Count==1, do not pop the last entry; restart the counter and keep showing it.
  - SHOW never returns to IDLE except by Rst.
- When Freeze==1, the counter and pops are inhibited. Pushes still occur. An overflow while frozen still advances the head, so the display changes. The counter does not restart.
- Any head change caused by overflow resets the hold counter to 0.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is one bit wider so it can represent DEPTH.

## Timing
- Reset (async assert): pointers=0, Count=0, counter=0, Overflow=0, state IDLE, all outputs 0. Deassertion is synchronous to Clk by the top-level reset scheme.
- Push latency: an entry pushed at edge N is in storage after edge N. If the FIFO was empty, Disp* and DispValid reflect it in cycle N+1, i.e. after edge N.
- Disp* are a read mux of registered storage at the head pointer. There are no additional pipeline registers.
- Advance latency: the pop occurs at the edge where the counter equals HOLD_CYCLES-1, and the new head is visible immediately after that edge. Each entry is shown for exactly HOLD_CYCLES cycles when Freeze=0 and there is no overflow.
- Count updates on the same edge as the push or pop.
- Reset mid-display discards all entries immediately and asynchronously.

## Test plan
Bench settings: DEPTH=4, HOLD_CYCLES=4 unless stated.
- Reset, then no writes -> DispValid=0, Disp*=0, Count=0 indefinitely.
- Single push (WrAddr=5, WrData=0x1234, WrPC=0x40) -> next cycle DispValid=1, DispData=0x1234, DispPC=0x040, DispAddr=5; Count stays 1 and the display holds beyond 4 cycles.
- Three pushes on consecutive cycles (data 1, 2, 3) -> DispData shows 1 for 4 cycles, then 2 for 4 cycles, then 3 thereafter; Count goes 3→2→1.
- Push with WrAddr=0 and FILTER_ZERO=1 -> Count unchanged and no display change. Repeat with FILTER_ZERO=0 -> entry captured.
- Five pushes (data 1..5) with no pops -> Overflow=1 after the fifth, Count=4, DispData=2. Overflow remains 1 after the FIFO drains.
- Freeze=1 asserted mid-hold with 2 entries, held 20 cycles -> DispData unchanged and Count stays 2; after Freeze drops, the remaining hold cycles elapse before the advance. Assert Rst mid-hold -> immediate IDLE with all outputs 0.
